chunked_add_sub: RTL

Parametrised multi-cycle two's-complement adder/subtractor. Processes WIDTH-bit operands CHUNK bits per clock, with the carry registered between chunks. Adds a valid/ready handshake on both sides, signed status flags, and an optional saturating mode. Used as the shared arithmetic unit behind datapath blocks that trade latency for a short carry chain.

---
 rtl/chunked_add_sub.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/chunked_add_sub.sv
// Multi-cycle two's-complement adder/subtractor: CHUNK bits per cycle with a registered carry,
// valid/ready on both sides, signed status flags and optional saturation.
module chunked_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             m,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned NUM_CHUNKS = WIDTH / CHUNK;
  localparam int unsigned IdxW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("chunked_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic              sat_q, sat_d, carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  int unsigned       base;
  logic [CHUNK:0]    csum;
  logic              raw_ovf;
  logic [WIDTH-1:0]  final_sum;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sat_d     = sat_q;
    carry_d   = carry_q;
    idx_d     = idx_q;
    res_d     = res_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    raw_ovf   = 1'b0;
    final_sum = res_q;

    base = 32'(idx_q) * CHUNK;
    csum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
         + {{CHUNK{1'b0}}, carry_q};

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with m.
          a_d     = a;
          b_d     = b ^ {WIDTH{m}};
          sat_d   = sat;
          carry_d = m;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d[base +: CHUNK] = csum[CHUNK-1:0];
        carry_d              = csum[CHUNK];
        idx_d                = idx_q + IdxW'(1);
        if (idx_q == IdxW'(NUM_CHUNKS - 1)) begin
          // Same-sign operands producing an opposite-sign result == carry-in XOR carry-out of MSB.
          raw_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
          final_sum = res_d;
          if (sat_q && raw_ovf) begin
            final_sum = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
          sum_d   = final_sum;
          cout_d  = csum[CHUNK];
          ovf_d   = raw_ovf;
          zero_d  = (final_sum == '0);
          neg_d   = final_sum[WIDTH-1];
          idx_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
  assign neg       = neg_q;

endmodule
